// File: rtl/top_sdram_controller.sv
// SDRAM controller with built-in self-test: initialises the device, writes one
// burst of an incrementing pattern to bank 0 / row 0 / column 0, reads it back and compares.
module top_sdram_controller #(
    parameter logic [2:0] BL                = 3'b011,
    parameter logic [1:0] BURST_ACCESS_TYPE = 2'b00,
    parameter int         wr_burst_len      = 8,
    parameter int         rd_burst_len      = 8,
    parameter int         T_RP              = 4,
    parameter int         T_RC              = 6,
    parameter int         T_MRD             = 6,
    parameter int         T_RCD             = 2,
    parameter int         T_WR              = 3,
    parameter int         CASn              = 3,
    parameter int         SDR_BA_WIDTH      = 2,
    parameter int         SDR_ROW_WIDTH     = 13,
    parameter int         SDR_COL_WIDTH     = 9,
    parameter int         SDR_DQ_WIDTH      = 16,
    parameter int         SDR_DQM_WIDTH     = 2,
    parameter int         APP_ADDR_WIDTH    = 24,
    parameter int         APP_BURST_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         sdram_cke,
    output logic                         sdram_cs_n,
    output logic                         sdram_ras_n,
    output logic                         sdram_cas_n,
    output logic                         sdram_we_n,
    output logic [SDR_BA_WIDTH-1:0]      sdram_ba,
    output logic [SDR_ROW_WIDTH-1:0]     sdram_addr,
    output logic [SDR_DQM_WIDTH-1:0]     sdram_dqm,
    inout  wire logic [SDR_DQ_WIDTH-1:0] sdram_dq,
    output logic                         o_led_receive_done
);

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WR    = 4'b0100;
    localparam logic [3:0] CMD_RD    = 4'b0101;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

    // Fixed self-test location, split into bank/row/column like an application address.
    localparam logic [APP_ADDR_WIDTH-1:0] TEST_ADDR = '0;
    localparam logic [SDR_BA_WIDTH-1:0]   TEST_BA   = TEST_ADDR[SDR_COL_WIDTH+SDR_ROW_WIDTH +: SDR_BA_WIDTH];
    localparam logic [SDR_ROW_WIDTH-1:0]  TEST_ROW  = TEST_ADDR[SDR_COL_WIDTH +: SDR_ROW_WIDTH];
    localparam logic [SDR_ROW_WIDTH-1:0]  TEST_COL  = SDR_ROW_WIDTH'(TEST_ADDR[SDR_COL_WIDTH-1:0]);
    localparam logic [SDR_ROW_WIDTH-1:0]  ADDR_A10  = SDR_ROW_WIDTH'(11'h400);

    localparam logic [2:0] MODE_BL = (BURST_ACCESS_TYPE == 2'b00) ? BL :
                                     (BURST_ACCESS_TYPE == 2'b01) ? 3'b000 : 3'b111;
    localparam logic [SDR_ROW_WIDTH-1:0] MODE_ADDR = SDR_ROW_WIDTH'({3'(CASn), 1'b0, MODE_BL});

    localparam logic [7:0] C_INIT = 8'd199;
    localparam logic [7:0] C_RP   = 8'(T_RP - 1);
    localparam logic [7:0] C_RC   = 8'(T_RC - 1);
    localparam logic [7:0] C_MRD  = 8'(T_MRD - 1);
    localparam logic [7:0] C_RCD  = 8'(T_RCD - 1);
    localparam logic [7:0] C_WR   = 8'(T_WR - 1);
    localparam logic [7:0] C_WRRP = 8'(T_WR - 1 + T_RP);
    localparam logic [7:0] C_CL   = 8'(CASn - 2);
    localparam logic [7:0] C_RPD  = 8'(T_RP);
    localparam logic [APP_BURST_WIDTH-1:0] W_LAST = APP_BURST_WIDTH'(wr_burst_len - 1);
    localparam logic [APP_BURST_WIDTH-1:0] R_LAST = APP_BURST_WIDTH'(rd_burst_len - 1);

    typedef enum logic [3:0] {
        INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_LMR, IDLE,
        WR_ACT, WR_CMD, WR_DATA, WR_PRE, RD_ACT, RD_CMD, RD_DATA, RD_PRE, DONE
    } state_t;

    state_t                     r_state;
    logic [7:0]                 r_cnt;
    logic [APP_BURST_WIDTH-1:0] r_idx;
    logic [SDR_DQ_WIDTH-1:0]    r_word;
    logic                       r_dq_oe;
    logic                       r_err;
    logic                       r_cke;
    logic [3:0]                 r_cmd;
    logic [SDR_BA_WIDTH-1:0]    r_ba;
    logic [SDR_ROW_WIDTH-1:0]   r_addr;
    logic [SDR_DQM_WIDTH-1:0]   r_dqm;
    logic                       r_led;

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
    assign sdram_cke          = r_cke;
    assign sdram_ba           = r_ba;
    assign sdram_addr         = r_addr;
    assign sdram_dqm          = r_dqm;
    assign sdram_dq           = r_dq_oe ? r_word : 'z;
    assign o_led_receive_done = r_led;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT_WAIT;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_dq_oe <= 1'b0;
            r_err   <= 1'b0;
            r_cke   <= 1'b0;
            r_cmd   <= CMD_DESEL;
            r_ba    <= '0;
            r_addr  <= '0;
            r_dqm   <= '1;
            r_led   <= 1'b0;
        end else begin
            r_cmd <= CMD_NOP;
            r_cnt <= r_cnt + 1'b1;
            case (r_state)
                INIT_WAIT: begin
                    r_cke <= 1'b1;
                    if (r_cnt == C_INIT) begin
                        r_cmd <= CMD_PRE; r_addr <= ADDR_A10; r_cnt <= '0; r_state <= INIT_PRE;
                    end
                end
                INIT_PRE:  if (r_cnt == C_RP) begin r_cmd <= CMD_REF; r_cnt <= '0; r_state <= INIT_REF1; end
                INIT_REF1: if (r_cnt == C_RC) begin r_cmd <= CMD_REF; r_cnt <= '0; r_state <= INIT_REF2; end
                INIT_REF2: if (r_cnt == C_RC) begin
                    r_cmd <= CMD_LMR; r_ba <= '0; r_addr <= MODE_ADDR; r_cnt <= '0; r_state <= INIT_LMR;
                end
                INIT_LMR:  if (r_cnt == C_MRD) begin r_dqm <= '0; r_state <= IDLE; end
                IDLE: begin
                    r_cmd <= CMD_ACT; r_ba <= TEST_BA; r_addr <= TEST_ROW; r_cnt <= '0; r_state <= WR_ACT;
                end
                WR_ACT: if (r_cnt == C_RCD) begin
                    r_cmd <= CMD_WR; r_addr <= TEST_COL; r_dq_oe <= 1'b1;
                    r_word <= SDR_DQ_WIDTH'(1); r_idx <= '0; r_state <= WR_CMD;
                end
                // r_idx tracks the word currently on the bus; release after the last one.
                WR_CMD, WR_DATA: begin
                    if (r_idx == W_LAST) begin
                        r_dq_oe <= 1'b0; r_cnt <= '0; r_state <= WR_PRE;
                    end else begin
                        r_word <= r_word + 1'b1; r_idx <= r_idx + 1'b1; r_state <= WR_DATA;
                    end
                end
                WR_PRE: begin
                    if (r_cnt == C_WR) begin
                        r_cmd <= CMD_PRE; r_addr <= ADDR_A10;
                    end else if (r_cnt == C_WRRP) begin
                        r_cmd <= CMD_ACT; r_ba <= TEST_BA; r_addr <= TEST_ROW; r_cnt <= '0; r_state <= RD_ACT;
                    end
                end
                RD_ACT: if (r_cnt == C_RCD) begin
                    r_cmd <= CMD_RD; r_addr <= TEST_COL; r_cnt <= '0; r_state <= RD_CMD;
                end
                // Leave one cycle early so RD_DATA samples exactly CASn edges after READ.
                RD_CMD: if (r_cnt == C_CL) begin
                    r_idx <= '0; r_word <= SDR_DQ_WIDTH'(1); r_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (sdram_dq != r_word) r_err <= 1'b1;
                    r_word <= r_word + 1'b1;
                    if (r_idx == R_LAST) begin
                        r_cnt <= '0; r_state <= RD_PRE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                RD_PRE: begin
                    if (r_cnt == 8'd0) begin
                        r_cmd <= CMD_PRE; r_addr <= ADDR_A10;
                    end else if (r_cnt == C_RPD) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_cnt <= r_cnt;
                    r_led <= ~r_err;
                end
                default: r_state <= INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_top_sdram_controller.sv
// Self-test bench: two controller instances (default CL3/BL8 and CL2/BL4) each
// attached to a small behavioural SDRAM model that logs commands and stores writes.
module tb_top_sdram_controller;

    logic clk;
    logic rst;
    logic fault;
    int   n_total = 0;
    int   n_bad   = 0;

    always #10 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : m
        localparam int         CL  = (g == 0) ? 3 : 2;
        localparam int         NB  = (g == 0) ? 8 : 4;
        localparam logic [2:0] BLC = (g == 0) ? 3'b011 : 3'b010;

        wire  [15:0] dq;
        logic        m_oe;
        logic [15:0] m_dq;
        assign dq = m_oe ? m_dq : 'z;

        logic        cke, cs_n, ras_n, cas_n, we_n, led;
        logic [1:0]  ba, dqm;
        logic [12:0] addr;
        wire  [3:0]  cmd = {cs_n, ras_n, cas_n, we_n};

        top_sdram_controller #(
            .BL(BLC), .wr_burst_len(NB), .rd_burst_len(NB), .CASn(CL)
        ) dut (
            .clk(clk), .rst(rst), .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
            .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_ba(ba), .sdram_addr(addr),
            .sdram_dqm(dqm), .sdram_dq(dq), .o_led_receive_done(led)
        );

        logic [15:0] mem     [16];
        logic [3:0]  log_cmd [32];
        logic [12:0] log_a   [32];
        logic [1:0]  log_dqm [32];
        int          log_t   [32];
        int          n_cmd, n_wr, wr_k, rd_k, last_wr, k_now, j_now;
        int          cyc = 0;
        logic        rd_on;
        logic [3:0]  wr_col;

        always_comb begin
            k_now = (cmd == 4'b0101) ? 0 : rd_k + 1;
            j_now = k_now - (CL - 2);
        end

        always @(posedge clk) begin
            cyc <= cyc + 1;
            if (rst) begin
                n_cmd <= 0; n_wr <= 0; wr_k <= NB; rd_k <= 0; rd_on <= 1'b0; m_oe <= 1'b0;
                wr_col <= '0; last_wr <= 0;
                for (int i = 0; i < 16; i++) mem[i] <= '0;
            end else begin
                if (!cs_n && cmd != 4'b0111 && n_cmd < 32) begin
                    log_cmd[n_cmd] <= cmd; log_a[n_cmd] <= addr; log_dqm[n_cmd] <= dqm;
                    log_t[n_cmd] <= cyc; n_cmd <= n_cmd + 1;
                end
                if (cmd == 4'b0100) begin
                    mem[addr[3:0]] <= dq; wr_col <= addr[3:0] + 4'd1; wr_k <= 1;
                    n_wr <= n_wr + 1; last_wr <= cyc;
                end else if (wr_k < NB) begin
                    mem[wr_col] <= dq; wr_col <= wr_col + 4'd1; wr_k <= wr_k + 1;
                    n_wr <= n_wr + 1; last_wr <= cyc;
                end
                if (cmd == 4'b0101) begin
                    rd_on <= 1'b1; rd_k <= 0;
                end else if (rd_on) begin
                    rd_k <= rd_k + 1;
                end
                if (cmd == 4'b0101 || rd_on) begin
                    if (j_now >= 0 && j_now < NB) begin
                        m_oe <= 1'b1;
                        m_dq <= (fault && g == 0 && j_now == 5) ? 16'hDEAD : mem[4'(j_now)];
                    end else if (j_now >= NB) begin
                        m_oe <= 1'b0; rd_on <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_cke"},  {31'd0, m[0].cke},  32'd0);
        chk({pfx, "_cmd"},  {28'd0, m[0].cmd},  32'hF);
        chk({pfx, "_ba"},   {30'd0, m[0].ba},   32'd0);
        chk({pfx, "_addr"}, {19'd0, m[0].addr}, 32'd0);
        chk({pfx, "_dqm"},  {30'd0, m[0].dqm},  32'd3);
        chk({pfx, "_led"},  {31'd0, m[0].led},  32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(m[0].n_cmd >= 10 && m[1].n_cmd >= 10) && n < 2000) begin
            @(negedge clk); n++;
        end
        chk("done_timeout", n < 2000, 1);
        repeat (12) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [3:0] exp_seq [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_seq = '{4'h2, 4'h1, 4'h1, 4'h0, 4'h3, 4'h4, 4'h2, 4'h3, 4'h5, 4'h2};
        clk = 1'b0; rst = 1'b1; fault = 1'b0;
        #50;
        chk_reset("rst0");
        #50 rst = 1'b0;

        // Pass case on both instances
        wait_done();
        for (int i = 0; i < 10; i++) chk($sformatf("seq%0d", i), {28'd0, m[0].log_cmd[i]}, {28'd0, exp_seq[i]});
        chk("lmr_addr",  {19'd0, m[0].log_a[3]}, 32'h33);
        chk("pre_ref",   m[0].log_t[1] - m[0].log_t[0] >= 4, 1);
        chk("ref_ref",   m[0].log_t[2] - m[0].log_t[1] >= 6, 1);
        chk("lmr_act",   m[0].log_t[4] - m[0].log_t[3] >= 6, 1);
        chk("act_wr",    m[0].log_t[5] - m[0].log_t[4], 2);
        chk("act_rd",    m[0].log_t[8] - m[0].log_t[7], 2);
        chk("wr_pre",    m[0].log_t[6] - m[0].last_wr >= 3, 1);
        chk("dqm_lmr",   {30'd0, m[0].log_dqm[3]}, 32'd3);
        chk("dqm_act",   {30'd0, m[0].log_dqm[4]}, 32'd0);
        chk("n_wr",      m[0].n_wr, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("mem%0d", i), {16'd0, m[0].mem[i]}, 32'(i + 1));
        chk("mem8_untouched", {16'd0, m[0].mem[8]}, 32'd0);
        chk("led_pass",  {31'd0, m[0].led}, 32'd1);
        chk("v_lmr_addr", {19'd0, m[1].log_a[3]}, 32'h22);
        chk("v_n_wr",    m[1].n_wr, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("v_mem%0d", i), {16'd0, m[1].mem[i]}, 32'(i + 1));
        chk("v_mem4_untouched", {16'd0, m[1].mem[4]}, 32'd0);
        chk("v_led",     {31'd0, m[1].led}, 32'd1);

        // Fault case: read word 5 corrupted on the default instance
        fault = 1'b1;
        do_reset();
        wait_done();
        chk("led_fault", {31'd0, m[0].led}, 32'd0);
        chk("v_led_nofault", {31'd0, m[1].led}, 32'd1);
        fault = 1'b0;

        // Reset mid-read, then full rerun
        do_reset();
        begin
            int n = 0;
            while (!(m[0].rd_on && m[0].rd_k >= 3) && n < 2000) begin
                @(negedge clk); n++;
            end
            chk("rd_timeout", n < 2000, 1);
        end
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_done();
        chk("rerun_first_pre", {28'd0, m[0].log_cmd[0]}, 32'h2);
        chk("rerun_lmr_addr",  {19'd0, m[0].log_a[3]}, 32'h33);
        chk("rerun_led",       {31'd0, m[0].led}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
